chess_turn_ctrl: RTL

//  Game-flow sequencer between mouse_position decode and chess_board/figure_move_logic.

---
 rtl/chess_turn_ctrl_if.sv | 36 +++
 rtl/chess_turn_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/chess_turn_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : chess_turn_ctrl_if
// Description : Mouse/board bundle between the board decode, the turn
//               sequencer (slave) and the board logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface chess_turn_ctrl_if;
    logic        mouse_left;
    logic [5:0]  mouse_square;
    logic        mouse_on_board;
    logic [3:0]  square_code;
    logic [63:0] possible_moves;
    logic        pick_piece;
    logic        place_piece;
    logic [5:0]  sel_square;
    logic [5:0]  target_square;
    logic        sel_active;
    logic        turn;
    logic [9:0]  move_count;
    logic        illegal;
    logic        timeout;

    modport master (
        output mouse_left, mouse_square, mouse_on_board, square_code, possible_moves,
        input  pick_piece, place_piece, sel_square, target_square, sel_active,
               turn, move_count, illegal, timeout
    );

    modport slave (
        input  mouse_left, mouse_square, mouse_on_board, square_code, possible_moves,
        output pick_piece, place_piece, sel_square, target_square, sel_active,
               turn, move_count, illegal, timeout
    );
endinterface
`default_nettype wire

// File: rtl/chess_turn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : chess_turn_ctrl
// Description : Turns synchronised LMB clicks on board squares into
//               pick/place pulses, enforcing side-to-move and legal targets.
//               Define SEL_TIMEOUT_EN to auto-cancel a held piece.
// Revision    : 1.0 - initial release
// ============================================================================
module chess_turn_ctrl #(
    parameter int          SYNC_STAGES    = 2,
    parameter int          MOVES_LAT      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 650_000_000
) (
    input  wire              clk,
    input  wire              rst,
    chess_turn_ctrl_if.slave bus
);

    localparam int             c_WAIT_W    = (MOVES_LAT > 1) ? $clog2(MOVES_LAT) : 1;
    localparam [c_WAIT_W-1:0]  c_WAIT_LOAD = c_WAIT_W'(MOVES_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PICK   = 3'd1,
        S_WAIT   = 3'd2,
        S_HOLD   = 3'd3,
        S_PLACE  = 3'd4,
        S_CANCEL = 3'd5,
        S_TOUT   = 3'd6
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_last;
    logic                   r_evt;
    state_t                 r_state;
    logic [c_WAIT_W-1:0]    r_wait_cnt;
    logic                   r_pick;
    logic                   r_place;
    logic [5:0]             r_sel_square;
    logic [5:0]             r_target;
    logic                   r_sel_active;
    logic                   r_turn;
    logic [9:0]             r_move_count;
    logic                   r_illegal;
    logic                   w_click;
    logic                   w_own_piece;

    assign w_click     = r_evt & bus.mouse_on_board;
    assign w_own_piece = (bus.square_code != 4'h0) && (bus.square_code[3] == r_turn);

    // Rising edge of the synchronised button, registered so it is a clean 1-cycle event
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync      <= '0;
            r_sync_last <= 1'b0;
            r_evt       <= 1'b0;
        end else begin
            r_sync      <= {r_sync[SYNC_STAGES-2:0], bus.mouse_left};
            r_sync_last <= r_sync[SYNC_STAGES-1];
            r_evt       <= r_sync[SYNC_STAGES-1] & ~r_sync_last;
        end
    end

`ifdef SEL_TIMEOUT_EN
    localparam logic [31:0] c_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_tmo_cnt;
    logic        r_timeout;
    assign bus.timeout = r_timeout;
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYCLES;
    assign bus.timeout  = 1'b0;
`endif

    // Pulse outputs are registered on entry to the state that owns them
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_pick       <= 1'b0;
            r_place      <= 1'b0;
            r_sel_square <= '0;
            r_target     <= '0;
            r_sel_active <= 1'b0;
            r_turn       <= 1'b0;
            r_move_count <= '0;
            r_illegal    <= 1'b0;
`ifdef SEL_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_timeout    <= 1'b0;
`endif
        end else begin
            r_pick    <= 1'b0;
            r_place   <= 1'b0;
            r_illegal <= 1'b0;
`ifdef SEL_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_click && w_own_piece) begin
                        r_sel_square <= bus.mouse_square;
                        r_pick       <= 1'b1;
                        r_sel_active <= 1'b1;
                        r_state      <= S_PICK;
                    end
                end
                S_PICK: begin
                    r_wait_cnt <= c_WAIT_LOAD;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state <= S_HOLD;
`ifdef SEL_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
`ifdef SEL_TIMEOUT_EN
                    r_tmo_cnt <= r_tmo_cnt + 32'd1;
`endif
                    if (w_click) begin
                        if (bus.possible_moves[bus.mouse_square]) begin
                            r_target     <= bus.mouse_square;
                            r_place      <= 1'b1;
                            r_sel_active <= 1'b0;
                            r_turn       <= ~r_turn;
                            if (r_move_count != 10'h3FF)
                                r_move_count <= r_move_count + 10'd1;
                            r_state      <= S_PLACE;
                        end else if (bus.mouse_square == r_sel_square) begin
                            r_target     <= r_sel_square;
                            r_place      <= 1'b1;
                            r_sel_active <= 1'b0;
                            r_state      <= S_CANCEL;
                        end else begin
                            r_illegal <= 1'b1;
                        end
                    end
`ifdef SEL_TIMEOUT_EN
                    else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_timeout <= 1'b1;
                        r_state   <= S_TOUT;
                    end
`endif
                end
                // Timeout announced last cycle; now put the piece back
                S_TOUT: begin
                    r_target     <= r_sel_square;
                    r_place      <= 1'b1;
                    r_sel_active <= 1'b0;
                    r_state      <= S_CANCEL;
                end
                S_PLACE, S_CANCEL: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pick_piece    = r_pick;
    assign bus.place_piece   = r_place;
    assign bus.sel_square    = r_sel_square;
    assign bus.target_square = r_target;
    assign bus.sel_active    = r_sel_active;
    assign bus.turn          = r_turn;
    assign bus.move_count    = r_move_count;
    assign bus.illegal       = r_illegal;

endmodule
`default_nettype wire
